// File: rtl/issue_cdb_scheduler.sv
// Round-robin issue arbiter with CDB writeback slot reservation and long-unit occupancy tracking.
// Optional ISSUE_CDB_SCHED_PERF_EN adds grant/stall performance counters.
module issue_cdb_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int OP_W      = 7,
    parameter int TAG_W     = 32,
    parameter int SHORT_LAT = 1,
    parameter int LONG_LAT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_long,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     issue_valid,
    output logic [OP_W-1:0]          issue_op,
    output logic [TAG_W-1:0]         issue_tag,
    output logic                     issue_long,
    output logic                     CDB_valid,
    output logic [TAG_W-1:0]         CDB_tag,
    output logic                     long_busy,
    output logic [31:0]              perf_grant_cnt,
    output logic [31:0]              perf_stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [3:0]       busy_cnt;
    logic             wb_valid [0:LONG_LAT];
    logic [TAG_W-1:0] wb_tag   [0:LONG_LAT];

    logic             sh_valid  [0:LONG_LAT];
    logic             nxt_valid [0:LONG_LAT];
    logic [TAG_W-1:0] nxt_tag   [0:LONG_LAT];
    logic [NUM_REQ-1:0] eligible;
    logic             found;
    logic [PTR_W-1:0] win;
    int               win_lat;

    // Slot check looks at the shifted state so a broadcast this cycle never blocks a grant.
    always_comb begin
        for (int k = 0; k < LONG_LAT; k++) begin
            sh_valid[k] = wb_valid[k+1];
        end
        sh_valid[LONG_LAT] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !flush
                          && !sh_valid[req_long[i] ? LONG_LAT : SHORT_LAT]
                          && (!req_long[i] || busy_cnt == 4'd0);
        end
    end

    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        grant   = found ? (NUM_REQ'(1) << win) : '0;
        win_lat = req_long[win] ? LONG_LAT : SHORT_LAT;
    end

    always_comb begin
        for (int k = 0; k < LONG_LAT; k++) begin
            nxt_valid[k] = sh_valid[k];
            nxt_tag[k]   = wb_tag[k+1];
        end
        nxt_valid[LONG_LAT] = 1'b0;
        nxt_tag[LONG_LAT]   = '0;
        if (found) begin
            nxt_valid[win_lat] = 1'b1;
            nxt_tag[win_lat]   = req_tag[int'(win)*TAG_W +: TAG_W];
        end
        if (flush) begin
            for (int k = 0; k <= LONG_LAT; k++) nxt_valid[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            busy_cnt    <= '0;
            issue_valid <= 1'b0;
            issue_op    <= '0;
            issue_tag   <= '0;
            issue_long  <= 1'b0;
            CDB_valid   <= 1'b0;
            CDB_tag     <= '0;
            for (int k = 0; k <= LONG_LAT; k++) begin
                wb_valid[k] <= 1'b0;
                wb_tag[k]   <= '0;
            end
        end else begin
            for (int k = 0; k <= LONG_LAT; k++) begin
                wb_valid[k] <= nxt_valid[k];
                wb_tag[k]   <= nxt_tag[k];
            end
            CDB_valid   <= nxt_valid[0];
            CDB_tag     <= nxt_tag[0];
            issue_valid <= found;
            if (found) begin
                rr_ptr     <= (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
                issue_op   <= req_op[int'(win)*OP_W +: OP_W];
                issue_tag  <= req_tag[int'(win)*TAG_W +: TAG_W];
                issue_long <= req_long[win];
            end
            if (flush)
                busy_cnt <= '0;
            else if (found && req_long[win])
                busy_cnt <= 4'(LONG_LAT-1);
            else if (busy_cnt != 4'd0)
                busy_cnt <= busy_cnt - 4'd1;
        end
    end

    assign long_busy = (busy_cnt != 4'd0);

`ifdef ISSUE_CDB_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (found) perf_grant_cnt <= perf_grant_cnt + 32'd1;
            if (|req_valid && !flush && !found) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_grant_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Directed self-checking bench for issue_cdb_scheduler: issue, round-robin, long spacing,
// CDB collision avoidance, flush and optional perf counters.
module tb_issue_cdb_scheduler;

    localparam int NUM_REQ = 4;
    localparam int OP_W    = 7;
    localparam int TAG_W   = 32;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_long = '0;
    logic [NUM_REQ*OP_W-1:0]  req_op = '0;
    logic [NUM_REQ*TAG_W-1:0] req_tag = '0;
    logic                     flush = 1'b0;
    logic [NUM_REQ-1:0]       grant;
    logic                     issue_valid;
    logic [OP_W-1:0]          issue_op;
    logic [TAG_W-1:0]         issue_tag;
    logic                     issue_long;
    logic                     CDB_valid;
    logic [TAG_W-1:0]         CDB_tag;
    logic                     long_busy;
    logic [31:0]              perf_grant_cnt;
    logic [31:0]              perf_stall_cnt;

    int errors = 0;
    int checks = 0;

    issue_cdb_scheduler dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_long(req_long), .req_op(req_op), .req_tag(req_tag),
        .flush(flush), .grant(grant),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_tag(issue_tag),
        .issue_long(issue_long), .CDB_valid(CDB_valid), .CDB_tag(CDB_tag),
        .long_busy(long_busy), .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_long  = '0;
        req_op    = '0;
        req_tag   = '0;
        flush     = 1'b0;
    endtask

    task automatic set_req(input int b, input logic lng, input logic [OP_W-1:0] op,
                           input logic [TAG_W-1:0] tag);
        req_valid[b]               = 1'b1;
        req_long[b]                = lng;
        req_op[b*OP_W +: OP_W]     = op;
        req_tag[b*TAG_W +: TAG_W]  = tag;
    endtask

    task automatic expect_cdb(input string name, input logic v, input logic [TAG_W-1:0] tag);
        check({name, "_cdb_valid"}, 64'(CDB_valid), 64'(v));
        if (v) check({name, "_cdb_tag"}, 64'(CDB_tag), 64'(tag));
    endtask

    // Leaves the bench at the start of cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        clear_req();
        @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_issue_tag", 64'(issue_tag), 64'd0);
        check("rst_cdb_valid", 64'(CDB_valid), 64'd0);
        check("rst_long_busy", 64'(long_busy), 64'd0);
        check("rst_perf_grant", 64'(perf_grant_cnt), 64'd0);
        check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Single short op from bank 2, then wrap of the pointer back to bank 0
        do_reset();
        set_req(2, 1'b0, 7'h33, 32'd5);
        #1 check("s1_grant_c0", 64'(grant), 64'b0100);
        next_cycle(); clear_req();
        #1 check("s1_grant_c1", 64'(grant), 64'd0);
        check("s1_issue_valid", 64'(issue_valid), 64'd1);
        check("s1_issue_op", 64'(issue_op), 64'h33);
        check("s1_issue_tag", 64'(issue_tag), 64'd5);
        check("s1_issue_long", 64'(issue_long), 64'd0);
        expect_cdb("s1_c1", 1'b0, '0);
        next_cycle();
        #1 expect_cdb("s1_c2", 1'b1, 32'd5);
        check("s1_issue_valid_c2", 64'(issue_valid), 64'd0);
        next_cycle();
        set_req(0, 1'b0, 7'h01, 32'd6);
        set_req(1, 1'b0, 7'h02, 32'd7);
        #1 check("s1_wrap_grant", 64'(grant), 64'b0001);
        expect_cdb("s1_c3", 1'b0, '0);

        // Round-robin fairness: all banks hold short requests for 4 cycles
        do_reset();
        for (int b = 0; b < NUM_REQ; b++) set_req(b, 1'b0, 7'(b + 8), 32'(10 + b));
        for (int c = 0; c < 6; c++) begin
            if (c == 4) clear_req();
            #1 check($sformatf("s2_grant_c%0d", c), 64'(grant), (c < 4) ? 64'(1 << c) : 64'd0);
            if (c >= 2) expect_cdb($sformatf("s2_c%0d", c), 1'b1, 32'(10 + c - 2));
            next_cycle();
        end

        // Long-unit spacing
        do_reset();
        set_req(0, 1'b1, 7'h11, 32'd20);
        #1 check("s3_grant_c0", 64'(grant), 64'b0001);
        next_cycle(); clear_req();
        set_req(1, 1'b1, 7'h12, 32'd21);
        #1 check("s3_issue_long_c1", 64'(issue_long), 64'd1);
        check("s3_issue_tag_c1", 64'(issue_tag), 64'd20);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) #1;
            check($sformatf("s3_grant_c%0d", c), 64'(grant), 64'd0);
            check($sformatf("s3_busy_c%0d", c), 64'(long_busy), 64'd1);
            next_cycle();
        end
        #1 check("s3_grant_c4", 64'(grant), 64'b0010);
        check("s3_busy_c4", 64'(long_busy), 64'd0);
        next_cycle(); clear_req();
        #1 expect_cdb("s3_c5", 1'b1, 32'd20);
        check("s3_busy_c5", 64'(long_busy), 64'd1);
`ifdef ISSUE_CDB_SCHED_PERF_EN
        check("s3_perf_grant", 64'(perf_grant_cnt), 64'd2);
        check("s3_perf_stall", 64'(perf_stall_cnt), 64'd3);
`else
        check("s3_perf_grant", 64'(perf_grant_cnt), 64'd0);
        check("s3_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        for (int c = 6; c <= 8; c++) begin
            next_cycle();
            #1 expect_cdb($sformatf("s3_c%0d", c), 1'b0, '0);
        end
        next_cycle();
        #1 expect_cdb("s3_c9", 1'b1, 32'd21);
        next_cycle();
        #1 expect_cdb("s3_c10", 1'b0, '0);

        // CDB collision avoidance
        do_reset();
        set_req(0, 1'b1, 7'h21, 32'd30);
        #1 check("s4_grant_c0", 64'(grant), 64'b0001);
        next_cycle(); clear_req();
        next_cycle();
        next_cycle();
        set_req(1, 1'b0, 7'h22, 32'd31);
        #1 check("s4_grant_c3", 64'(grant), 64'd0);
        next_cycle();
        #1 check("s4_grant_c4", 64'(grant), 64'b0010);
        next_cycle(); clear_req();
        #1 expect_cdb("s4_c5", 1'b1, 32'd30);
        next_cycle();
        #1 expect_cdb("s4_c6", 1'b1, 32'd31);
        next_cycle();
        #1 expect_cdb("s4_c7", 1'b0, '0);

        // Flush kills the in-flight long op; round-robin pointer survives
        do_reset();
        set_req(0, 1'b1, 7'h31, 32'd40);
        #1 check("s5_grant_c0", 64'(grant), 64'b0001);
        next_cycle(); clear_req();
        #1 check("s5_issue_valid_c1", 64'(issue_valid), 64'd1);
        next_cycle();
        set_req(3, 1'b0, 7'h32, 32'd43);
        flush = 1'b1;
        #1 check("s5_grant_c2", 64'(grant), 64'd0);
        next_cycle(); clear_req();
        #1 check("s5_issue_valid_c3", 64'(issue_valid), 64'd0);
        check("s5_busy_c3", 64'(long_busy), 64'd0);
        expect_cdb("s5_c3", 1'b0, '0);
        for (int c = 4; c <= 5; c++) begin
            next_cycle();
            #1 expect_cdb($sformatf("s5_c%0d", c), 1'b0, '0);
        end
        next_cycle();
        set_req(0, 1'b0, 7'h01, 32'd44);
        set_req(3, 1'b0, 7'h02, 32'd45);
        #1 check("s5_rr_hold_grant", 64'(grant), 64'b1000);
        next_cycle(); clear_req();
        #1 check("s5_rr_issue_tag", 64'(issue_tag), 64'd45);

        // Asynchronous reset mid-operation
        set_req(1, 1'b1, 7'h41, 32'd50);
        next_cycle();
        #1 reset = 1'b1;
        #1 check("async_rst_issue_valid", 64'(issue_valid), 64'd0);
        check("async_rst_long_busy", 64'(long_busy), 64'd0);
        reset = 1'b0;
        clear_req();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/issue_cdb_scheduler.md
Name: issue_cdb_scheduler

Overview:
- Select/issue arbiter between NUM_REQ reservation-station banks and the shared execution back end.
- Each cycle it grants at most one ready RS entry (round-robin), registers the issued operation toward the FUs, and schedules that operation's CDB writeback slot. The schedule prevents CDB collisions and keeps the non-pipelined long-latency unit from being oversubscribed.
- It drives CDB_valid/CDB_tag, which every RS bank and the map table consume.

Parameters:
- NUM_REQ, 4, number of requesting RS banks (≥2).
- OP_W, 7, opcode width.
- TAG_W, 32, physical-register tag width.
- SHORT_LAT, 1, execute latency of the pipelined short unit (≥1).
- LONG_LAT, 4, execute latency of the non-pipelined long unit (SHORT_LAT < LONG_LAT ≤ 15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  bank i presents a ready entry
- req_long  in  NUM_REQ  bank i's op targets the long unit
- req_op  in  NUM_REQ*OP_W  opcodes, bank i at [i*OP_W +: OP_W]
- req_tag  in  NUM_REQ*TAG_W  destination tags, bank i at [i*TAG_W +: TAG_W]
- flush  in  1  ROB precise-state recovery; kills all in-flight scheduling
- grant  out  NUM_REQ  combinational one-hot; bank frees its entry this cycle
- issue_valid  out  1  registered; op sent to FU
- issue_op  out  OP_W  registered opcode
- issue_tag  out  TAG_W  registered destination tag
- issue_long  out  1  registered unit select
- CDB_valid  out  1  registered broadcast valid
- CDB_tag  out  TAG_W  registered broadcast tag
- long_busy  out  1  busy_cnt != 0

Behaviour:
- Reset clears all state: every output 0; rr_ptr=0, busy_cnt=0, all wb slots invalid.
- State:
  - rr_ptr, range 0..NUM_REQ-1.
  - busy_cnt, 4 bits.
  - wb[0..LONG_LAT], each {valid, tag}.
  - Issue register.
- Per-request latency: L = LONG_LAT if req_long[i], else SHORT_LAT.
- Slot shift each cycle: wb_next[k] = wb[k+1] for k < LONG_LAT; wb_next[LONG_LAT] is invalid.
- Eligibility of bank i: req_valid[i] && !flush && !wb_next[L].valid && (!req_long[i] || busy_cnt==0).
- Winner: first eligible index scanning rr_ptr, rr_ptr+1, … with wrap. grant is one-hot on the winner, all-zero if none.
- On a grant at cycle t:
  - wb_next[L] <= {1, req_tag[w]}.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - Issue register loads {1, op, tag, long} and is visible at t+1.
  - If long, busy_cnt <= LONG_LAT-1.
- With no grant, issue_valid <= 0 and rr_ptr holds.
- busy_cnt decrements by 1 each cycle when nonzero.
  - Consequence: back-to-back long grants are spaced exactly LONG_LAT cycles.
  - LONG_LAT=1 is disallowed by the parameter rule.
- CDB timing: CDB_valid/CDB_tag are registered from wb_next[0]. An op granted at t broadcasts during cycle t+L+1, exactly one cycle.
- At most one CDB broadcast per cycle is guaranteed by the slot check.
- Simultaneous broadcast and grant in the same cycle is legal; the slot check uses the shifted (next) state.
- Flush, checked before any other update:
  - grant forced to 0.
  - Next cycle: issue_valid=0 and CDB_valid=0.
  - All wb slots are invalidated and busy_cnt is cleared.
  - rr_ptr holds.
- A broadcast already in the CDB register during the flush cycle is still seen; nothing later is.
- Asserting reset mid-operation returns to the reset state immediately; in-flight ops are lost.
- grant depends combinationally on req_* and flush. Banks must not make req_valid depend on grant.

Optional Feature:
- Macro ISSUE_CDB_SCHED_PERF_EN.
- When defined, two 32-bit wrap-around counters exist, cleared by reset and by nothing else:
  - perf_grant_cnt (out 32) increments on every cycle with a grant.
  - perf_stall_cnt (out 32) increments on every cycle where |req_valid and !flush but no grant is given (structural stall).
- When not defined, both ports are still present and tied to 0, with no counter flops.

Test Plan:
- Single short op: bank 2 requests, op=7'h33, tag=5, cycle 0. Response: grant=4'b0100 at cycle 0; issue_valid, tag 5 at cycle 1; CDB_valid, CDB_tag=5 at cycle 2 only.
- Round-robin fairness: all 4 banks hold short requests for 4 cycles from reset. Response: grants go 0,1,2,3 in order, one per cycle; CDB shows their tags in cycles 2..5.
- Long-unit spacing: bank 0 long at cycle 0 and bank 1 long from cycle 1. Response:
  - bank 1 is blocked at cycles 1..3 and granted at cycle 4;
  - long_busy is high at cycles 1..3;
  - CDB tags appear at cycles 5 and 9.
- CDB collision: bank 0 long granted at cycle 0 (slot hits cycle 5); bank 1 short requests at cycle 3, which would also broadcast at cycle 5. Response: bank 1 is denied at cycle 3, granted at cycle 4, broadcasts at cycle 6.
- Flush: long op granted at cycle 0, flush at cycle 2 with bank 3 requesting. Response: grant=0 at cycle 2; no CDB_valid at cycles 3..5; long_busy=0 at cycle 3.
- Perf counters (macro on): run scenario 3. Response: perf_grant_cnt=2 and perf_stall_cnt=3 at cycle 5.
